// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - RV32I five-stage control decode, branch resolve and hazard unit
//
// Decodes the D-stage instruction, carries control through E/M/W registers,
// resolves branches/jal in E and produces stall/flush/forwarding controls.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_d, valid_d              D-stage instruction and its valid flag
//   zero_e, lt_e, ltu_e           E-stage ALU compare flags
//   alusrc_e, alucontrol_e        E-stage ALU controls
//   pcsrc_e                       PC redirect (taken branch or jal)
//   memwrite_m, memread_m, rd_m   M-stage memory controls and destination
//   regwrite_w, resultsrc_w, rd_w W-stage writeback controls and destination
//   forward_a_e, forward_b_e      operand forwarding selects
//   stall_f, stall_d, flush_d,
//   flush_e                       hazard controls
//   illegal_d                     unsupported valid D-stage instruction
module pipelined_control_unit #(
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1,
    parameter int BR_EXT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_d,
    input  logic            valid_d,
    input  logic            zero_e,
    input  logic            lt_e,
    input  logic            ltu_e,
    output logic            alusrc_e,
    output logic [2:0]      alucontrol_e,
    output logic            pcsrc_e,
    output logic [1:0]      memwrite_m,
    output logic [2:0]      memread_m,
    output logic            regwrite_w,
    output logic [1:0]      resultsrc_w,
    output logic [RA_W-1:0] rd_m,
    output logic [RA_W-1:0] rd_w,
    output logic [1:0]      forward_a_e,
    output logic [1:0]      forward_b_e,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e,
    output logic            illegal_d
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_LD  = 7'b0000011;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_OR  = 3'b011, ALU_PASSB = 3'b100, ALU_SLT = 3'b101,
                           ALU_XOR = 3'b110, ALU_SRL = 3'b111;

    localparam logic [1:0] RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_5;
    logic       w_unused;

    assign w_opcode   = instr_d[6:0];
    assign w_funct3   = instr_d[14:12];
    assign w_funct7_5 = instr_d[30];
    assign w_unused   = ^{instr_d[31], instr_d[29:7]};

    logic       w_legal, w_rri_ok;
    logic       w_regwrite, w_jump, w_branch, w_alusrc, w_use_rs1, w_use_rs2;
    logic [1:0] w_resultsrc, w_memwrite;
    logic [2:0] w_memread, w_alucontrol, w_alu_rri;
    logic [RA_W-1:0] w_rd_d, w_rs1_d, w_rs2_d;

    // ALU op shared by R-type and I-ALU; sll/sltu func3 are not supported
    always_comb begin
        w_rri_ok  = 1'b1;
        w_alu_rri = ALU_ADD;
        case (w_funct3)
            3'b000:  w_alu_rri = (w_opcode == OP_R && w_funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_rri = ALU_SLT;
            3'b100:  w_alu_rri = ALU_XOR;
            3'b101:  w_alu_rri = ALU_SRL;
            3'b110:  w_alu_rri = ALU_OR;
            3'b111:  w_alu_rri = ALU_AND;
            default: w_rri_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_legal      = 1'b0;
        w_regwrite   = 1'b0;
        w_resultsrc  = RES_ALU;
        w_memwrite   = 2'b00;
        w_memread    = 3'b000;
        w_jump       = 1'b0;
        w_branch     = 1'b0;
        w_alusrc     = 1'b0;
        w_alucontrol = ALU_ADD;
        w_use_rs1    = 1'b0;
        w_use_rs2    = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_legal = w_rri_ok; w_regwrite = 1'b1; w_alucontrol = w_alu_rri;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            OP_I: begin
                w_legal = w_rri_ok; w_regwrite = 1'b1; w_alusrc = 1'b1;
                w_alucontrol = w_alu_rri; w_use_rs1 = 1'b1;
            end
            OP_LUI: begin
                w_legal = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1; w_alucontrol = ALU_PASSB;
            end
            OP_JAL: begin
                w_legal = 1'b1; w_regwrite = 1'b1; w_resultsrc = RES_PC4; w_jump = 1'b1;
            end
            OP_BR: begin
                // func3 010/011 are never branches; without BR_EXT only beq/bne
                w_legal = (BR_EXT != 0) ? (w_funct3[2:1] != 2'b01) : (w_funct3[2:1] == 2'b00);
                w_branch = 1'b1; w_alucontrol = ALU_SUB;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            OP_ST: begin
                w_legal = !w_funct3[2] && (w_funct3[1:0] != 2'b11);
                w_memwrite = w_funct3[1:0] + 2'd1;
                w_alusrc = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            OP_LD: begin
                w_legal = 1'b1; w_regwrite = 1'b1; w_resultsrc = RES_MEM;
                w_alusrc = 1'b1; w_use_rs1 = 1'b1;
                case (w_funct3)
                    3'b000:  w_memread = 3'b001;
                    3'b001:  w_memread = 3'b010;
                    3'b010:  w_memread = 3'b000;
                    3'b100:  w_memread = 3'b011;
                    3'b101:  w_memread = 3'b100;
                    default: w_legal   = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
        // Invalid or unsupported instructions decode as a bubble
        if (!(valid_d && w_legal)) begin
            w_regwrite   = 1'b0;
            w_resultsrc  = RES_ALU;
            w_memwrite   = 2'b00;
            w_memread    = 3'b000;
            w_jump       = 1'b0;
            w_branch     = 1'b0;
            w_alusrc     = 1'b0;
            w_alucontrol = ALU_ADD;
            w_use_rs1    = 1'b0;
            w_use_rs2    = 1'b0;
        end
    end

    assign illegal_d = valid_d & ~w_legal;

    // Unused fields are zeroed so x0 semantics cover "no dependency"
    assign w_rd_d  = w_regwrite ? instr_d[7 +: RA_W]  : '0;
    assign w_rs1_d = w_use_rs1  ? instr_d[15 +: RA_W] : '0;
    assign w_rs2_d = w_use_rs2  ? instr_d[20 +: RA_W] : '0;

    logic            r_regwrite_e, r_jump_e, r_branch_e, r_alusrc_e;
    logic [1:0]      r_resultsrc_e, r_memwrite_e;
    logic [2:0]      r_memread_e, r_alucontrol_e, r_funct3_e;
    logic [RA_W-1:0] r_rd_e, r_rs1_e, r_rs2_e;
    logic            r_regwrite_m, r_regwrite_w;
    logic [1:0]      r_resultsrc_m, r_memwrite_m, r_resultsrc_w;
    logic [2:0]      r_memread_m;
    logic [RA_W-1:0] r_rd_m, r_rd_w;

    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            r_regwrite_e <= 1'b0; r_resultsrc_e <= RES_ALU; r_memwrite_e <= 2'b00;
            r_memread_e <= 3'b000; r_jump_e <= 1'b0; r_branch_e <= 1'b0;
            r_alusrc_e <= 1'b0; r_alucontrol_e <= ALU_ADD; r_funct3_e <= 3'b000;
            r_rd_e <= '0; r_rs1_e <= '0; r_rs2_e <= '0;
        end else begin
            r_regwrite_e <= w_regwrite; r_resultsrc_e <= w_resultsrc; r_memwrite_e <= w_memwrite;
            r_memread_e <= w_memread; r_jump_e <= w_jump; r_branch_e <= w_branch;
            r_alusrc_e <= w_alusrc; r_alucontrol_e <= w_alucontrol; r_funct3_e <= w_funct3;
            r_rd_e <= w_rd_d; r_rs1_e <= w_rs1_d; r_rs2_e <= w_rs2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regwrite_m <= 1'b0; r_resultsrc_m <= RES_ALU; r_memwrite_m <= 2'b00;
            r_memread_m <= 3'b000; r_rd_m <= '0;
            r_regwrite_w <= 1'b0; r_resultsrc_w <= RES_ALU; r_rd_w <= '0;
        end else begin
            r_regwrite_m <= r_regwrite_e; r_resultsrc_m <= r_resultsrc_e;
            r_memwrite_m <= r_memwrite_e; r_memread_m <= r_memread_e; r_rd_m <= r_rd_e;
            r_regwrite_w <= r_regwrite_m; r_resultsrc_w <= r_resultsrc_m; r_rd_w <= r_rd_m;
        end
    end

    logic w_cond, w_dep_e, w_dep_m, w_hazard;

    always_comb begin
        w_cond = 1'b0;
        case (r_funct3_e)
            3'b000:  w_cond = zero_e;
            3'b001:  w_cond = ~zero_e;
            3'b100:  w_cond = lt_e;
            3'b101:  w_cond = ~lt_e;
            3'b110:  w_cond = ltu_e;
            3'b111:  w_cond = ~ltu_e;
            default: w_cond = 1'b0;
        endcase
    end

    assign pcsrc_e = r_jump_e | (r_branch_e & w_cond);

    assign w_dep_e = (r_rd_e != '0) && (r_rd_e == w_rs1_d || r_rd_e == w_rs2_d);
    assign w_dep_m = (r_rd_m != '0) && (r_rd_m == w_rs1_d || r_rd_m == w_rs2_d);

    // With forwarding only a load in E needs a bubble; without it every E/M writer does
    assign w_hazard = (FWD_EN != 0)
                    ? (r_regwrite_e && (r_resultsrc_e == RES_MEM) && w_dep_e)
                    : ((r_regwrite_e && w_dep_e) || (r_regwrite_m && w_dep_m));

    // A redirect discards D anyway, so it overrides any stall
    assign stall_f = w_hazard & ~pcsrc_e;
    assign stall_d = w_hazard & ~pcsrc_e;
    assign flush_d = pcsrc_e;
    assign flush_e = pcsrc_e | w_hazard;

    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (FWD_EN != 0) begin
            if (r_regwrite_m && r_rd_m != '0 && r_rd_m == r_rs1_e)      forward_a_e = 2'b10;
            else if (r_regwrite_w && r_rd_w != '0 && r_rd_w == r_rs1_e) forward_a_e = 2'b01;
            if (r_regwrite_m && r_rd_m != '0 && r_rd_m == r_rs2_e)      forward_b_e = 2'b10;
            else if (r_regwrite_w && r_rd_w != '0 && r_rd_w == r_rs2_e) forward_b_e = 2'b01;
        end
    end

    assign alusrc_e     = r_alusrc_e;
    assign alucontrol_e = r_alucontrol_e;
    assign memwrite_m   = r_memwrite_m;
    assign memread_m    = r_memread_m;
    assign rd_m         = r_rd_m;
    assign regwrite_w   = r_regwrite_w;
    assign resultsrc_w  = r_resultsrc_w;
    assign rd_w         = r_rd_w;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - self-checking bench for pipelined_control_unit
module tb_pipelined_control_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [31:0] instr_d = 32'h0;
    logic        valid_d = 1'b0;
    logic        zero_e = 1'b0, lt_e = 1'b0, ltu_e = 1'b0;
    logic        alusrc_e, pcsrc_e, regwrite_w, stall_f, stall_d, flush_d, flush_e, illegal_d;
    logic [2:0]  alucontrol_e, memread_m;
    logic [1:0]  memwrite_m, resultsrc_w, forward_a_e, forward_b_e;
    logic [4:0]  rd_m, rd_w;

    logic [31:0] instr_nf = 32'h0, instr_nb = 32'h0;
    logic        valid_nf = 1'b0, valid_nb = 1'b0;
    logic        alusrc_nf, pcsrc_nf, regwrite_nf, stall_f_nf, stall_d_nf, flush_d_nf, flush_e_nf, illegal_nf;
    logic [2:0]  alucontrol_nf, memread_nf;
    logic [1:0]  memwrite_nf, resultsrc_nf, forward_a_nf, forward_b_nf;
    logic [4:0]  rd_m_nf, rd_w_nf;
    logic        alusrc_nb, pcsrc_nb, regwrite_nb, stall_f_nb, stall_d_nb, flush_d_nb, flush_e_nb, illegal_nb;
    logic [2:0]  alucontrol_nb, memread_nb;
    logic [1:0]  memwrite_nb, resultsrc_nb, forward_a_nb, forward_b_nb;
    logic [4:0]  rd_m_nb, rd_w_nb;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d),
        .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .alusrc_e(alusrc_e), .alucontrol_e(alucontrol_e), .pcsrc_e(pcsrc_e),
        .memwrite_m(memwrite_m), .memread_m(memread_m), .regwrite_w(regwrite_w),
        .resultsrc_w(resultsrc_w), .rd_m(rd_m), .rd_w(rd_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .illegal_d(illegal_d));

    pipelined_control_unit #(.FWD_EN(0)) dut_nf (
        .clk(clk), .rst(rst), .instr_d(instr_nf), .valid_d(valid_nf),
        .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .alusrc_e(alusrc_nf), .alucontrol_e(alucontrol_nf), .pcsrc_e(pcsrc_nf),
        .memwrite_m(memwrite_nf), .memread_m(memread_nf), .regwrite_w(regwrite_nf),
        .resultsrc_w(resultsrc_nf), .rd_m(rd_m_nf), .rd_w(rd_w_nf),
        .forward_a_e(forward_a_nf), .forward_b_e(forward_b_nf),
        .stall_f(stall_f_nf), .stall_d(stall_d_nf), .flush_d(flush_d_nf), .flush_e(flush_e_nf),
        .illegal_d(illegal_nf));

    pipelined_control_unit #(.BR_EXT(0)) dut_nb (
        .clk(clk), .rst(rst), .instr_d(instr_nb), .valid_d(valid_nb),
        .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .alusrc_e(alusrc_nb), .alucontrol_e(alucontrol_nb), .pcsrc_e(pcsrc_nb),
        .memwrite_m(memwrite_nb), .memread_m(memread_nb), .regwrite_w(regwrite_nb),
        .resultsrc_w(resultsrc_nb), .rd_m(rd_m_nb), .rd_w(rd_w_nb),
        .forward_a_e(forward_a_nb), .forward_b_e(forward_b_nb),
        .stall_f(stall_f_nb), .stall_d(stall_d_nb), .flush_d(flush_d_nb), .flush_e(flush_e_nb),
        .illegal_d(illegal_nb));

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (main instance, default parameters) ----------------
    typedef enum logic [2:0] {K_BUB, K_R, K_I, K_LUI, K_JAL, K_BR, K_ST, K_LD} kind_t;
    typedef struct {
        kind_t      k;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic       f7;
    } ins_t;

    function automatic bit m_legal(logic [31:0] ins, bit br_ext);
        logic [2:0] f3 = ins[14:12];
        case (ins[6:0])
            7'h33, 7'h13: return !(f3 == 3'd1 || f3 == 3'd3);
            7'h37, 7'h6F: return 1'b1;
            7'h63:        return br_ext ? !(f3 == 3'd2 || f3 == 3'd3) : (f3 <= 3'd1);
            7'h23:        return f3 <= 3'd2;
            7'h03:        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            default:      return 1'b0;
        endcase
    endfunction

    function automatic bit m_writes(kind_t k);
        return k inside {K_R, K_I, K_LUI, K_JAL, K_LD};
    endfunction

    function automatic ins_t m_decode(logic [31:0] ins, logic v);
        ins_t r;
        r.k = K_BUB; r.rd = 0; r.rs1 = 0; r.rs2 = 0; r.f3 = 0; r.f7 = 0;
        if (v && m_legal(ins, 1'b1)) begin
            case (ins[6:0])
                7'h33:   r.k = K_R;
                7'h13:   r.k = K_I;
                7'h37:   r.k = K_LUI;
                7'h6F:   r.k = K_JAL;
                7'h63:   r.k = K_BR;
                7'h23:   r.k = K_ST;
                default: r.k = K_LD;
            endcase
            r.f3 = ins[14:12];
            r.f7 = ins[30];
            if (m_writes(r.k)) r.rd = ins[11:7];
            if (r.k inside {K_R, K_I, K_BR, K_ST, K_LD}) r.rs1 = ins[19:15];
            if (r.k inside {K_R, K_BR, K_ST}) r.rs2 = ins[24:20];
        end
        return r;
    endfunction

    function automatic logic [2:0] m_alu(ins_t e);
        case (e.k)
            K_BR:  return 3'd1;
            K_LUI: return 3'd4;
            K_R, K_I:
                case (e.f3)
                    3'd0: return (e.k == K_R && e.f7) ? 3'd1 : 3'd0;
                    3'd2: return 3'd5;
                    3'd4: return 3'd6;
                    3'd5: return 3'd7;
                    3'd6: return 3'd3;
                    3'd7: return 3'd2;
                    default: return 3'd0;
                endcase
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] m_memread(ins_t m);
        if (m.k != K_LD) return 3'd0;
        case (m.f3)
            3'd0: return 3'd1;
            3'd1: return 3'd2;
            3'd4: return 3'd3;
            3'd5: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic bit m_taken(ins_t e, logic z, logic l, logic lu);
        if (e.k == K_JAL) return 1'b1;
        if (e.k != K_BR) return 1'b0;
        case (e.f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_dep(logic [4:0] rd, ins_t d);
        return rd != 0 && (rd == d.rs1 || rd == d.rs2);
    endfunction

    function automatic logic [1:0] m_fwd(logic [4:0] rs, ins_t m, ins_t w);
        if (rs != 0 && m_writes(m.k) && m.rd == rs) return 2'b10;
        if (rs != 0 && m_writes(w.k) && w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    ins_t me, mm, mw, nd, cd;
    bit   mdl_ok = 1'b0;
    bit   ntk, nhz, ctk, chz;

    always @(posedge clk) begin
        if (rst) begin
            me.k <= K_BUB; me.rd <= 0; me.rs1 <= 0; me.rs2 <= 0; me.f3 <= 0; me.f7 <= 0;
            mm.k <= K_BUB; mm.rd <= 0; mm.rs1 <= 0; mm.rs2 <= 0; mm.f3 <= 0; mm.f7 <= 0;
            mw.k <= K_BUB; mw.rd <= 0; mw.rs1 <= 0; mw.rs2 <= 0; mw.f3 <= 0; mw.f7 <= 0;
            mdl_ok <= 1'b1;
        end else begin
            nd  = m_decode(instr_d, valid_d);
            ntk = m_taken(me, zero_e, lt_e, ltu_e);
            nhz = (me.k == K_LD) && m_dep(me.rd, nd);
            mw <= mm;
            mm <= me;
            if (ntk || nhz) begin
                me.k <= K_BUB; me.rd <= 0; me.rs1 <= 0; me.rs2 <= 0; me.f3 <= 0; me.f7 <= 0;
            end else begin
                me <= nd;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            cd  = m_decode(instr_d, valid_d);
            ctk = m_taken(me, zero_e, lt_e, ltu_e);
            chz = (me.k == K_LD) && m_dep(me.rd, cd);
            chk("alusrc_e", alusrc_e, 32'(me.k inside {K_I, K_LUI, K_LD, K_ST}));
            chk("alucontrol_e", alucontrol_e, 32'(m_alu(me)));
            chk("pcsrc_e", pcsrc_e, 32'(ctk));
            chk("memwrite_m", memwrite_m, (mm.k == K_ST) ? 32'(mm.f3[1:0]) + 1 : 0);
            chk("memread_m", memread_m, 32'(m_memread(mm)));
            chk("regwrite_w", regwrite_w, 32'(m_writes(mw.k)));
            chk("resultsrc_w", resultsrc_w, (mw.k == K_LD) ? 1 : (mw.k == K_JAL) ? 2 : 0);
            chk("rd_m", rd_m, 32'(mm.rd));
            chk("rd_w", rd_w, 32'(mw.rd));
            chk("forward_a_e", forward_a_e, 32'(m_fwd(me.rs1, mm, mw)));
            chk("forward_b_e", forward_b_e, 32'(m_fwd(me.rs2, mm, mw)));
            chk("stall_f", stall_f, 32'(chz && !ctk));
            chk("stall_d", stall_d, 32'(chz && !ctk));
            chk("flush_d", flush_d, 32'(ctk));
            chk("flush_e", flush_e, 32'(ctk || chz));
            chk("illegal_d", illegal_d, 32'(valid_d && !m_legal(instr_d, 1'b1)));
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] ADDI1 = 32'h00500093, ADDI2 = 32'h00108113, ADD4 = 32'h00008233;
    localparam logic [31:0] LW5 = 32'h0000A283, ADD6 = 32'h00228333, BEQ = 32'h00000463;
    localparam logic [31:0] ADDI7 = 32'h00300393, JAL1 = 32'h010000EF, BLT = 32'h00004063;

    logic [31:0] p_nf_i = 0, p_nb_i = 0;
    logic        p_nf_v = 0, p_nb_v = 0, p_rst = 0;

    task automatic cycf(input logic [31:0] ins, input logic v, input logic z, input logic l, input logic lu);
        @(posedge clk);
        #1;
        rst = p_rst; instr_d = ins; valid_d = v; zero_e = z; lt_e = l; ltu_e = lu;
        instr_nf = p_nf_i; valid_nf = p_nf_v; instr_nb = p_nb_i; valid_nb = p_nb_v;
        @(negedge clk);
    endtask

    task automatic cyc(input logic [31:0] ins, input logic v);
        cycf(ins, v, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] vec [18] = '{32'h0020A223, 32'h00010183, 32'h0021D203, 32'h403202B3,
                              32'h0032A333, 32'h005363B3, 32'h0013D433, 32'h12345437,
                              32'h00029463, 32'h00526063, 32'h00004063, 32'hFFFFFFFF,
                              32'h00209033, 32'h00F47493, 32'h00941123, 32'h0014C513,
                              32'h00054583, 32'h00500093};
    int nf_stalls;
    bit nf_fwd_nz;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        instr_d = $urandom; valid_d = 1'b1;
        // reset: two cycles, then release
        p_rst = 1; cyc($urandom, 1'b1);
        p_rst = 0; cyc(32'h0, 1'b0);
        chk("rst_regwrite_w", regwrite_w, 0);
        chk("rst_pcsrc_e", pcsrc_e, 0);
        chk("rst_stall_f", stall_f, 0);
        chk("rst_rd_w", rd_w, 0);
        chk("rst_nf_stall_f", stall_f_nf, 0);

        // forwarding from M then W
        cyc(ADDI1, 1); cyc(ADDI2, 1); cyc(ADD4, 1);
        chk("fwd_m_a", forward_a_e, 2'b10);
        cyc(0, 0);
        chk("fwd_w_a", forward_a_e, 2'b01);
        repeat (3) cyc(0, 0);

        // load-use
        cyc(LW5, 1); cyc(ADD6, 1);
        chk("lu_stall_f", stall_f, 1); chk("lu_stall_d", stall_d, 1);
        chk("lu_flush_e", flush_e, 1); chk("lu_flush_d", flush_d, 0);
        cyc(ADD6, 1);
        chk("lu_stall_once", stall_f, 0); chk("lu_memread_m", memread_m, 3'b000);
        cyc(0, 0);
        chk("lu_fwd_a", forward_a_e, 2'b01); chk("lu_resultsrc_w", resultsrc_w, 2'b01);
        chk("lu_rd_w", rd_w, 5);
        repeat (3) cyc(0, 0);

        // beq taken / not taken
        cyc(BEQ, 1); cycf(ADDI7, 1, 1, 0, 0);
        chk("beq_pcsrc", pcsrc_e, 1); chk("beq_flush_d", flush_d, 1);
        chk("beq_flush_e", flush_e, 1); chk("beq_stall", stall_f, 0);
        cyc(0, 0);
        chk("beq_flushed_e", alusrc_e, 0);
        cyc(BEQ, 1); cycf(ADDI7, 1, 0, 0, 0);
        chk("bnt_pcsrc", pcsrc_e, 0); chk("bnt_flush_d", flush_d, 0); chk("bnt_flush_e", flush_e, 0);
        cyc(0, 0);
        chk("bnt_next_alusrc", alusrc_e, 1);
        repeat (3) cyc(0, 0);

        // jal
        cyc(JAL1, 1); cyc(0, 0);
        chk("jal_pcsrc", pcsrc_e, 1);
        cyc(0, 0); cyc(0, 0);
        chk("jal_resultsrc_w", resultsrc_w, 2'b10); chk("jal_regwrite_w", regwrite_w, 1);
        chk("jal_rd_w", rd_w, 1);
        repeat (3) cyc(0, 0);

        // mixed decode coverage, checked by the model
        for (int i = 0; i < 18; i++)
            cycf(vec[i], (i != 17), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        repeat (3) cyc(0, 0);

        // reset in the middle of a load-use stall
        cyc(LW5, 1);
        p_rst = 1; cyc(ADD6, 1);
        chk("rst_mid_stall_before", stall_f, 1);
        p_rst = 0; cyc(ADD6, 1);
        chk("rst_mid_stall_after", stall_f, 0); chk("rst_mid_memread", memread_m, 0);
        repeat (3) cyc(0, 0);

        // FWD_EN=0: addi pair stalls twice, never forwards
        nf_stalls = 0; nf_fwd_nz = 0;
        p_nf_i = ADDI1; p_nf_v = 1; cyc(0, 0);
        for (int i = 0; i < 3; i++) begin
            p_nf_i = ADDI2; cyc(0, 0);
            nf_stalls += int'(stall_f_nf);
            nf_fwd_nz |= (forward_a_nf != 0) || (forward_b_nf != 0);
        end
        p_nf_v = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0);
            nf_stalls += int'(stall_f_nf);
            nf_fwd_nz |= (forward_a_nf != 0) || (forward_b_nf != 0);
        end
        chk("nf_stall_cycles", nf_stalls, 2);
        chk("nf_no_forward", 32'(nf_fwd_nz), 0);
        // redirect beats a pending RAW stall
        p_nf_i = JAL1; p_nf_v = 1; cyc(0, 0);
        p_nf_i = ADDI2; cyc(0, 0);
        chk("nf_jal_pcsrc", pcsrc_nf, 1); chk("nf_jal_stall", stall_f_nf, 0);
        chk("nf_jal_flush_e", flush_e_nf, 1);
        cyc(0, 0);
        chk("nf_stall_m_writer", stall_d_nf, 1);
        p_nf_v = 0; repeat (3) cyc(0, 0);

        // BR_EXT=0: blt is illegal and enters E as a bubble
        p_nb_i = BLT; p_nb_v = 1; cyc(0, 0);
        chk("nb_illegal", illegal_nb, 1);
        p_nb_v = 0; cycf(0, 0, 0, 1, 0);
        chk("nb_bubble_pcsrc", pcsrc_nb, 0); chk("nb_bubble_alu", alucontrol_nb, 3'b000);
        p_nb_i = BEQ; p_nb_v = 1; cyc(0, 0);
        chk("nb_beq_legal", illegal_nb, 0);
        p_nb_v = 0; repeat (2) cyc(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Five-stage (F/D/E/M/W) successor to the single-cycle RV32I control decoder. It decodes the D-stage instruction and carries control words through internal E, M and W pipeline registers. It resolves branches and jumps in E, and generates hazard controls (stall, flush, forwarding) for the datapath. Control encodings are unchanged from the single-cycle core.

Parameters:
RA_W, 5, register-address width (5 = RV32I, 4 = RV32E; upper rd/rs bits ignored when 4)
FWD_EN, 1, 1 = forwarding from M/W; 0 = no forwarding, stall on every E/M RAW dependency
BR_EXT, 1, 1 = beq/bne/blt/bge/bltu/bgeu; 0 = beq/bne only, other branch func3 decoded illegal

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
instr_d  in  32  D-stage instruction
valid_d  in  1  instr_d holds a real instruction
zero_e, lt_e, ltu_e  in  1 each  ALU flags for E-stage subtract (equal, signed less, unsigned less)
alusrc_e  out  1  ALU B = immediate
alucontrol_e  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 xor, 111 srl, 100 pass-B (lui)
pcsrc_e  out  1  redirect PC (taken branch or jal)
memwrite_m  out  2  00 none, 01 sb, 10 sh, 11 sw
memread_m  out  3  000 word/none, 001 lb, 010 lh, 011 lbu, 100 lhu
regwrite_w  out  1  register file write enable
resultsrc_w  out  2  00 ALU, 01 memory, 10 PC+4
rd_m, rd_w  out  RA_W  destination register in M and W
forward_a_e, forward_b_e  out  2  00 regfile, 01 W result, 10 M ALU result
stall_f, stall_d, flush_d, flush_e  out  1 each  hazard controls
illegal_d  out  1  D-stage opcode/func3 unsupported (combinational)

Behaviour:
- Decode is combinational from instr_d. Supported instructions: R-type 0110011, I-ALU 0010011, lui 0110111, jal 1101111, branch 1100011, store 0100011 (func3 000/001/010), load 0000011 (func3 000/001/010/100/101).
- ALU decode uses the single-cycle rules:
  - Load/store: add. Branch: sub. lui: pass-B.
  - R/I func3: 000 add, except sub for R-type with func7[5]=1; 010 slt; 100 xor; 101 srl; 110 or; 111 and.
- Illegal instruction or valid_d=0: bubble, i.e. all enables 0, rd 0. illegal_d=1 only when valid_d=1.
- E register: on rst or flush_e, loads bubble. Otherwise it loads the decoded D word plus rd, rs1, rs2 and branch func3.
- M register loads from E; W loads from M. Neither stalls. rst clears both.
- Latency: D->E 1 cycle, E->M 1 cycle, M->W 1 cycle.
- pcsrc_e = jump_e | (branch_e & cond):
  - beq: zero; bne: !zero; blt: lt; bge: !lt; bltu: ltu; bgeu: !ltu.
- Taken redirect (pcsrc_e=1): flush_d=1 and flush_e=1 in the same cycle. No stall is asserted that cycle; redirect has priority over load-use.
- Load-use (FWD_EN=1): E is a load, rd_e!=0, and rd_e equals rs1_d or rs2_d (only fields used by the D opcode). Response: stall_f=stall_d=1 and flush_e=1 for exactly one cycle.
- Forwarding (FWD_EN=1):
  - 10 when regwrite_m, rd_m!=0 and rd_m==rs_e. M has priority.
  - Else 01 when regwrite_w, rd_w!=0 and rd_w==rs_e.
  - Else 00.
- FWD_EN=0: forward_* is always 00. Stall (stall_f, stall_d, flush_e) while any E or M writer with nonzero rd matches a used D source. The register file resolves W by write-through.
- x0 never matches as a dependency.
- Reset outputs: all registered outputs 0, rd_m=rd_w=0, pcsrc_e=0. Hazard outputs 0 while E/M hold bubbles.
- Reset asserted mid-stall or mid-flush clears all stages. No stall persists after rst deasserts.

Test Plan:
- rst=1 for 2 cycles with a random instr_d -> all registered outputs 0, pcsrc_e=0, stall_*=0 the cycle after release.
- addi x1,x0,5 (0x00500093) then addi x2,x1,1 (0x00108113) back-to-back -> when the second is in E, forward_a_e=10; one cycle later with the first in W, a dependent instruction gets forward_a_e=01.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333) -> one cycle stall_f=stall_d=flush_e=1; add then reaches E with forward_a_e=01, memread_m=000 and resultsrc_w=01 for the lw.
- beq x0,x0,8 (0x00000463) with zero_e=1 -> pcsrc_e=1, flush_d=flush_e=1. Same instruction with zero_e=0 -> pcsrc_e=0 and no flush.
- jal x1,16 (0x010000EF) -> pcsrc_e=1; two cycles later resultsrc_w=10, regwrite_w=1, rd_w=1.
- BR_EXT=0 with blt (func3 100) -> illegal_d=1 and a bubble enters E. FWD_EN=0 with the addi pair above -> 2 stall cycles and forward_*=00 throughout.
